// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST  = 3'd0,
    ST_ACQUIRE  = 3'd1,
    ST_FILTER   = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_RUN      = 3'd4
  } pll_sup_state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop bit synchroniser with asynchronous active-low clear.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; the last flop is the synchronised output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up / lock supervisor: pulses PLL reset, filters lock, staggers
// domain reset release and recovers from lock loss.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned PLL_RESET_CYCLES = 16,
  parameter int unsigned ACQ_TIMEOUT      = 65536,
  parameter int unsigned LOCK_FILTER      = 1024,
  parameter int unsigned N_DOMAINS        = 2,
  parameter int unsigned STAGGER          = 8,
  parameter int unsigned CNT_W            = 8
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 pll_lock_raw,
  input  logic                 force_relock,
  input  logic                 clear_stats,
  output logic                 pll_resetb,
  output logic [N_DOMAINS-1:0] domain_rst_n,
  output logic                 ready,
  output logic                 lock_lost,
  output logic [CNT_W-1:0]     loss_count,
  output logic [CNT_W-1:0]     timeout_count,
  output logic [2:0]           state
);

  localparam int unsigned ACQ_TW  = cnt_width(ACQ_TIMEOUT - 1);
  localparam int unsigned AUX_MAX = max3(PLL_RESET_CYCLES - 1, LOCK_FILTER, STAGGER - 1);
  localparam int unsigned AUX_W   = cnt_width(AUX_MAX);

  pll_sup_state_t       state_q, state_n;
  logic [AUX_W-1:0]     aux_q, aux_n;      // reset length, filter count or stagger gap
  logic [ACQ_TW-1:0]    timer_q, timer_n;  // acquisition timer, runs in ACQUIRE and FILTER
  logic [N_DOMAINS-1:0] dom_n;
  logic [N_DOMAINS:0]   dom_ext;
  logic                 ready_n, lock_lost_n, pll_resetb_n;
  logic [CNT_W-1:0]     loss_n, tmo_n;
  logic                 loss_evt, tmo_evt;
  logic                 lock_gated, lock_s;

  // A lock seen while the PLL is held in reset is stale, so it is masked
  // before entering the synchroniser.
  assign lock_gated = pll_lock_raw & pll_resetb;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clock_in),
    .rst_n (reset_n),
    .d     (lock_gated),
    .q     (lock_s)
  );

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_n     = state_q;
    aux_n       = aux_q;
    timer_n     = timer_q;
    dom_n       = domain_rst_n;
    ready_n     = ready;
    lock_lost_n = clear_stats ? 1'b0 : lock_lost;
    loss_n      = clear_stats ? '0 : loss_count;
    tmo_n       = clear_stats ? '0 : timeout_count;
    loss_evt    = 1'b0;
    tmo_evt     = 1'b0;
    dom_ext     = {domain_rst_n, 1'b1};

    if (force_relock) begin
      state_n = ST_PLL_RST;
      aux_n   = AUX_W'(PLL_RESET_CYCLES - 1);
      dom_n   = '0;
      ready_n = 1'b0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (aux_q == '0) begin
            state_n = ST_ACQUIRE;
            timer_n = '0;
          end else begin
            aux_n = aux_q - AUX_W'(1);
          end
        end
        ST_ACQUIRE: begin
          if (timer_q == ACQ_TW'(ACQ_TIMEOUT - 1)) begin
            tmo_evt = 1'b1;
          end else begin
            timer_n = timer_q + ACQ_TW'(1);
            if (lock_s) begin
              state_n = ST_FILTER;
              aux_n   = AUX_W'(1);
            end
          end
        end
        ST_FILTER: begin
          if (timer_q == ACQ_TW'(ACQ_TIMEOUT - 1)) begin
            tmo_evt = 1'b1;
          end else begin
            timer_n = timer_q + ACQ_TW'(1);
            if (!lock_s) begin
              state_n = ST_ACQUIRE;
            end else if (aux_q == AUX_W'(LOCK_FILTER)) begin
              dom_n   = N_DOMAINS'(1);
              aux_n   = AUX_W'(STAGGER - 1);
              state_n = (&dom_n) ? ST_RUN : ST_RELEASE;
              ready_n = &dom_n;
            end else begin
              aux_n = aux_q + AUX_W'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (!lock_s) begin
            loss_evt = 1'b1;
          end else if (aux_q == '0) begin
            dom_n   = dom_ext[N_DOMAINS-1:0];
            aux_n   = AUX_W'(STAGGER - 1);
            state_n = (&dom_n) ? ST_RUN : ST_RELEASE;
            ready_n = &dom_n;
          end else begin
            aux_n = aux_q - AUX_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) loss_evt = 1'b1;
        end
        default: begin
          state_n = ST_PLL_RST;
          aux_n   = AUX_W'(PLL_RESET_CYCLES - 1);
          dom_n   = '0;
          ready_n = 1'b0;
        end
      endcase
    end

    if (loss_evt || tmo_evt) begin
      state_n = ST_PLL_RST;
      aux_n   = AUX_W'(PLL_RESET_CYCLES - 1);
      dom_n   = '0;
      ready_n = 1'b0;
    end
    if (loss_evt) begin
      lock_lost_n = 1'b1;
      loss_n      = (loss_n == '1) ? loss_n : loss_n + CNT_W'(1);
    end
    if (tmo_evt) begin
      tmo_n = (tmo_n == '1) ? tmo_n : tmo_n + CNT_W'(1);
    end

    pll_resetb_n = (state_n != ST_PLL_RST);
  end

  // State, counters and all outputs are registered.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_PLL_RST;
      aux_q         <= AUX_W'(PLL_RESET_CYCLES - 1);
      timer_q       <= '0;
      pll_resetb    <= 1'b0;
      domain_rst_n  <= '0;
      ready         <= 1'b0;
      lock_lost     <= 1'b0;
      loss_count    <= '0;
      timeout_count <= '0;
    end else begin
      state_q       <= state_n;
      aux_q         <= aux_n;
      timer_q       <= timer_n;
      pll_resetb    <= pll_resetb_n;
      domain_rst_n  <= dom_n;
      ready         <= ready_n;
      lock_lost     <= lock_lost_n;
      loss_count    <= loss_n;
      timeout_count <= tmo_n;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with hand-computed cycle expectations.
module tb_pll_lock_supervisor;

  logic       clock_in;
  logic       reset_n;
  logic       pll_lock_raw;
  logic       force_relock;
  logic       clear_stats;
  logic       pll_resetb;
  logic [2:0] domain_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [1:0] loss_count;
  logic [1:0] timeout_count;
  logic [2:0] state;

  int passed;
  int total;
  int cyc;

  pll_lock_supervisor #(
    .SYNC_STAGES      (2),
    .PLL_RESET_CYCLES (4),
    .ACQ_TIMEOUT      (32),
    .LOCK_FILTER      (8),
    .N_DOMAINS        (3),
    .STAGGER          (2),
    .CNT_W            (2)
  ) dut (
    .clock_in      (clock_in),
    .reset_n       (reset_n),
    .pll_lock_raw  (pll_lock_raw),
    .force_relock  (force_relock),
    .clear_stats   (clear_stats),
    .pll_resetb    (pll_resetb),
    .domain_rst_n  (domain_rst_n),
    .ready         (ready),
    .lock_lost     (lock_lost),
    .loss_count    (loss_count),
    .timeout_count (timeout_count),
    .state         (state)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  // Advance to edge number target (counted from the last reset release), 1 ns past the edge.
  task automatic adv_to(input int target);
    while (cyc < target) begin
      @(posedge clock_in);
      #1;
      cyc++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_resetb"}, pll_resetb, 1'b0);
    check({tag, "_dom"}, domain_rst_n, 3'b000);
    check({tag, "_ready"}, ready, 1'b0);
    check({tag, "_lost"}, lock_lost, 1'b0);
    check({tag, "_loss"}, loss_count, 2'd0);
    check({tag, "_tmo"}, timeout_count, 2'd0);
    check({tag, "_state"}, state, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    passed       = 0;
    total        = 0;
    cyc          = 0;
    reset_n      = 1'b0;
    pll_lock_raw = 1'b1;
    force_relock = 1'b0;
    clear_stats  = 1'b0;

    repeat (3) @(posedge clock_in);
    #1;
    check_reset_values("rst");

    // Clean bring-up with lock high from reset.
    reset_n = 1'b1;
    cyc     = 0;
    adv_to(3);  check("up_resetb_low", pll_resetb, 1'b0); check("up_st_rst", state, 3'd0);
    adv_to(4);  check("up_resetb_high", pll_resetb, 1'b1); check("up_st_acq", state, 3'd1);
    adv_to(7);  check("up_st_filter", state, 3'd2);
    adv_to(14); check("up_st_filter_end", state, 3'd2); check("up_dom_none", domain_rst_n, 3'b000);
    adv_to(15); check("up_st_release", state, 3'd3); check("up_dom_001", domain_rst_n, 3'b001);
    adv_to(16); check("up_dom_001_hold", domain_rst_n, 3'b001);
    adv_to(17); check("up_dom_011", domain_rst_n, 3'b011);
    adv_to(18); check("up_ready_early", ready, 1'b0);
    adv_to(19); check("up_dom_111", domain_rst_n, 3'b111); check("up_ready", ready, 1'b1);
    check("up_st_run", state, 3'd4);

    // Loss of lock in RUN: response on the third edge after the raw fall.
    pll_lock_raw = 1'b0;
    adv_to(21); check("loss_dom_hold", domain_rst_n, 3'b111); check("loss_ready_hold", ready, 1'b1);
    adv_to(22);
    check("loss_dom", domain_rst_n, 3'b000); check("loss_ready", ready, 1'b0);
    check("loss_lost", lock_lost, 1'b1); check("loss_cnt", loss_count, 2'd1);
    check("loss_state", state, 3'd0); check("loss_resetb", pll_resetb, 1'b0);
    pll_lock_raw = 1'b1;
    adv_to(37); check("rel_dom_001", domain_rst_n, 3'b001); check("rel_st", state, 3'd3);
    adv_to(39); check("rel_dom_011", domain_rst_n, 3'b011);
    adv_to(41); check("rel_dom_111", domain_rst_n, 3'b111); check("rel_ready", ready, 1'b1);

    // force_relock from RUN.
    force_relock = 1'b1;
    adv_to(42);
    force_relock = 1'b0;
    check("frun_dom", domain_rst_n, 3'b000); check("frun_state", state, 3'd0);
    check("frun_ready", ready, 1'b0); check("frun_loss", loss_count, 2'd1);
    check("frun_tmo", timeout_count, 2'd0); check("frun_lost", lock_lost, 1'b1);

    // force_relock during RELEASE with two domains out.
    adv_to(59); check("frel_pre_dom", domain_rst_n, 3'b011); check("frel_pre_st", state, 3'd3);
    force_relock = 1'b1;
    adv_to(60);
    force_relock = 1'b0;
    check("frel_dom", domain_rst_n, 3'b000); check("frel_state", state, 3'd0);
    check("frel_ready", ready, 1'b0); check("frel_loss", loss_count, 2'd1);
    check("frel_tmo", timeout_count, 2'd0);

    // Asynchronous reset in the middle of RELEASE.
    adv_to(77); check("arst_pre_dom", domain_rst_n, 3'b011);
    reset_n = 1'b0;
    #1;
    check_reset_values("arst");

    // Glitchy lock: 5 high, 1 low, then high.
    pll_lock_raw = 1'b0;
    repeat (2) @(posedge clock_in);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
    adv_to(4);  check("gl_st_acq", state, 3'd1);
    pll_lock_raw = 1'b1;
    adv_to(9);  pll_lock_raw = 1'b0;
    adv_to(10); pll_lock_raw = 1'b1;
    adv_to(11); check("gl_st_filter1", state, 3'd2);
    adv_to(12); check("gl_st_back_acq", state, 3'd1);
    adv_to(13); check("gl_st_filter2", state, 3'd2);
    adv_to(20); check("gl_st_filter_end", state, 3'd2); check("gl_dom_none", domain_rst_n, 3'b000);
    adv_to(21); check("gl_st_release", state, 3'd3); check("gl_dom_001", domain_rst_n, 3'b001);
    check("gl_tmo", timeout_count, 2'd0);
    adv_to(25); check("gl_ready", ready, 1'b1); check("gl_dom_111", domain_rst_n, 3'b111);

    // Plain loss, then a loss coinciding with clear_stats.
    pll_lock_raw = 1'b0;
    adv_to(28); check("l1_cnt", loss_count, 2'd1); check("l1_lost", lock_lost, 1'b1);
    check("l1_state", state, 3'd0);
    pll_lock_raw = 1'b1;
    adv_to(47); check("l2_ready", ready, 1'b1);
    pll_lock_raw = 1'b0;
    adv_to(49); clear_stats = 1'b1;
    adv_to(50);
    clear_stats = 1'b0;
    check("clr_loss_cnt", loss_count, 2'd1); check("clr_loss_lost", lock_lost, 1'b1);
    check("clr_loss_state", state, 3'd0);

    // Timeout with lock held low: PLL reset pulses every 36 cycles, counter saturates.
    adv_to(54);  check("to_st_acq", state, 3'd1); check("to_resetb_hi", pll_resetb, 1'b1);
    adv_to(85);  check("to_st_pre", state, 3'd1); check("to_tmo0", timeout_count, 2'd0);
    adv_to(86);  check("to_st_rst", state, 3'd0); check("to_tmo1", timeout_count, 2'd1);
    check("to_resetb_lo", pll_resetb, 1'b0);
    adv_to(89);  check("to_resetb_lo_end", pll_resetb, 1'b0);
    adv_to(90);  check("to_resetb_hi2", pll_resetb, 1'b1);
    adv_to(121); check("to_tmo1_hold", timeout_count, 2'd1);
    adv_to(122); check("to_tmo2", timeout_count, 2'd2);
    adv_to(158); check("to_tmo3", timeout_count, 2'd3);
    adv_to(194); check("to_tmo_sat", timeout_count, 2'd3); check("to_sat_state", state, 3'd0);

    // clear_stats on its own.
    clear_stats = 1'b1;
    adv_to(195);
    clear_stats = 1'b0;
    check("clr_tmo", timeout_count, 2'd0); check("clr_loss", loss_count, 2'd0);
    check("clr_lost", lock_lost, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
